// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_arb_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    // Width of the fetch starvation counter; holds FETCH_MAX_WAIT up to 15.
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and physical-memory handshake signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until valid (stages) / mem_req held until mem_ack (memory).
interface mem_port_arbiter_if
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    // memory stage
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    // stalls
    logic              stall_if;
    logic              stall_mem;
    // physical memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, stall_if, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Environment view: pipeline stages plus the memory.
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, stall_if, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Counts data grants won while a fetch waits; flags when fetch must be forced.
// Latency: forced flag is combinational from the registered count and if_req.
// Backpressure: none; clears on any fetch grant or when if_req drops.
module arb_starve_cnt
    import mips_arb_pkg::*;
#(
    parameter int FETCH_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic d_grant_i,
    input  logic i_grant_i,
    output logic forced_o
);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: clear on fetch grant / no fetch pending, bump on data grant.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || i_grant_i) begin
            cnt_d = '0;
        end else if (d_grant_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign forced_o = if_req_i && (cnt_q == STARVE_CNT_W'(FETCH_MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read) and mem stage (read/write); optional MEM_ARB_PERF_EN adds perf counters.
// Latency: request seen in IDLE -> mem_req next cycle -> valid one cycle after mem_ack (min 2 cycles).
// Backpressure: one access in flight; losers see stall_x until their valid pulse; mem_req held until mem_ack.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int FETCH_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cnt,
    output logic [31:0]         perf_force_cnt
`endif
);

    arb_state_t        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic forced;
    logic d_grant;
    logic i_grant;

    // Data wins unless the fetch has been starved long enough to be forced.
    assign d_grant = (state_q == IDLE) && bus.d_req && !forced;
    assign i_grant = (state_q == IDLE) && bus.if_req && (forced || !bus.d_req);

    arb_starve_cnt #(
        .FETCH_MAX_WAIT (FETCH_MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req_i  (bus.if_req),
        .d_grant_i (d_grant),
        .i_grant_i (i_grant),
        .forced_o  (forced)
    );

    // Arbitration FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_grant) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        state_q     <= BUSY_D;
                    end else if (i_grant) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        state_q     <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack) begin
                        if_rdata_q <= bus.mem_rdata;
                        mem_req_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        state_q    <= RESP_I;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        // Stores leave the last load data untouched.
                        if (!mem_we_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        state_q   <= RESP_D;
                    end
                end
                // No arbitration here: a just-served requester's stale req must not win again.
                RESP_I, RESP_D: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic [31:0] force_q;

    // Saturating counts of IDLE-cycle conflicts and forced fetch grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
            force_q    <= '0;
        end else begin
            if ((state_q == IDLE) && bus.if_req && bus.d_req && (conflict_q != '1)) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (i_grant && forced && (force_q != '1)) begin
                force_q <= force_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_force_cnt    = force_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple acking memory model.
// Latency: n/a.
// Backpressure: memory model acks after a programmable number of wait cycles.
module tb_mem_port_arbiter;
    import mips_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;
    int   ack_delay;
    int   wait_cnt;
    logic [31:0] rsp_data;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_force_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .FETCH_MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_force_cnt    (perf_force_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Move to just after the falling edge: far from the active edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model: acks after ack_delay wait cycles of a pending mem_req.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0BAD0;
        wait_cnt      = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_ack) begin
                if (wait_cnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rsp_data;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hBAD0BAD0;
                wait_cnt      = 0;
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        int nd;
        int cmax;
        logic done;

        n_chk = 0;
        n_bad = 0;
        ack_delay = 0;
        rsp_data  = 32'h0;
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        step();
        step();

        // ---- reset state ----
        chk("rst_mem_req",  bus.mem_req,  0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_d_valid",  bus.d_valid,  0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata",  bus.d_rdata,  0);
        chk("rst_stall_if", bus.stall_if, 0);
        chk("rst_state",    dut.state_q,  IDLE);
        chk("rst_cnt",      dut.u_starve.cnt_q, 0);
        rst_n = 1'b1;
        step();

        // ---- fetch only, ack in first busy cycle ----
        ack_delay   = 0;
        rsp_data    = 32'h8C220004;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        #1;
        chk("f_stall_if_req", bus.stall_if, 1);
        step();
        chk("f_mem_req",  bus.mem_req,  1);
        chk("f_mem_we",   bus.mem_we,   0);
        chk("f_mem_addr", bus.mem_addr, 32'h40);
        chk("f_if_valid_c1", bus.if_valid, 0);
        step();
        chk("f_if_valid_c2", bus.if_valid, 1);
        chk("f_if_rdata",    bus.if_rdata, 32'h8C220004);
        chk("f_mem_we_c2",   bus.mem_we,   0);
        chk("f_stall_if_c2", bus.stall_if, 0);
        bus.if_req = 1'b0;
        step();
        chk("f_if_valid_pulse", bus.if_valid, 0);
        chk("f_mem_req_idle",   bus.mem_req,  0);

        // ---- slow memory load, ack after 5 wait cycles ----
        ack_delay   = 5;
        rsp_data    = 32'h12345678;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h300;
        busy = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (bus.d_valid) begin
                done = 1'b1;
            end else begin
                busy++;
                chk("s_mem_req",   bus.mem_req,   1);
                chk("s_mem_addr",  bus.mem_addr,  32'h300);
                chk("s_mem_we",    bus.mem_we,    0);
                chk("s_stall_mem", bus.stall_mem, 1);
            end
        end
        chk("s_valid_seen", done, 1);
        chk("s_busy_cycles", busy, 6);
        chk("s_d_rdata", bus.d_rdata, 32'h12345678);
        chk("s_stall_mem_low", bus.stall_mem, 0);
        bus.d_req = 1'b0;
        step();

        // ---- conflict: store and fetch together ----
        ack_delay   = 0;
        rsp_data    = 32'hCAFE0001;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hDEADBEEF;
        step();
        chk("c_mem_we_store", bus.mem_we,    1);
        chk("c_mem_addr_st",  bus.mem_addr,  32'h100);
        chk("c_mem_wdata",    bus.mem_wdata, 32'hDEADBEEF);
        chk("c_stall_if_b",   bus.stall_if,  1);
        step();
        chk("c_d_valid",     bus.d_valid,  1);
        chk("c_d_rdata_st",  bus.d_rdata,  32'h12345678);
        chk("c_stall_if_r",  bus.stall_if, 1);
        bus.d_req = 1'b0;
        step();
        chk("c_idle_no_req", bus.mem_req,  0);
        chk("c_stall_if_i",  bus.stall_if, 1);
        step();
        chk("c_fetch_req",  bus.mem_req,  1);
        chk("c_fetch_we",   bus.mem_we,   0);
        chk("c_fetch_addr", bus.mem_addr, 32'h200);
        step();
        chk("c_if_valid", bus.if_valid, 1);
        chk("c_if_rdata", bus.if_rdata, 32'hCAFE0001);
        bus.if_req = 1'b0;
        step();

        // ---- starvation: both requests held continuously ----
        ack_delay   = 0;
        rsp_data    = 32'h00000011;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h600;
        nd   = 0;
        cmax = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (int'(dut.u_starve.cnt_q) > cmax) cmax = int'(dut.u_starve.cnt_q);
            if (bus.d_valid) nd++;
            if (bus.if_valid) done = 1'b1;
        end
        chk("v_fetch_served", done, 1);
        chk("v_data_grants",  nd,   4);
        chk("v_cnt_peak",     cmax, 4);
        chk("v_cnt_clear",    dut.u_starve.cnt_q, 0);
        chk("v_if_rdata",     bus.if_rdata, 32'h00000011);
`ifdef MEM_ARB_PERF_EN
        // 1 conflict cycle earlier + 5 here (4 data grants, 1 forced fetch).
        chk("p_conflict", perf_conflict_cnt, 6);
        chk("p_force",    perf_force_cnt,    1);
`endif
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();

        // ---- reset in the middle of a data access ----
        ack_delay   = 100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h400;
        step();
        chk("r_busy_req", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("r_async_drop", bus.mem_req, 0);
        bus.d_req = 1'b0;
        step();
        rst_n = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.d_valid) done = 1'b1;
        end
        chk("r_no_d_valid", done, 0);
        chk("r_state_idle", dut.state_q, IDLE);
        chk("r_mem_req",    bus.mem_req, 0);
`ifdef MEM_ARB_PERF_EN
        chk("p_rst_conflict", perf_conflict_cnt, 0);
        chk("p_rst_force",    perf_force_cnt,    0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
